// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flop, LSB first.
// The result, carry-out and signed overflow are registered and held between operations.
module serial_adder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] PENULT = CW'(N - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [N-1:0]  a_sh, b_sh, s_sh;
    logic          c, c_msb_in;
    logic [CW-1:0] cnt;
    logic          fa_s, fa_c;
    logic          done_r, cout_r, ovf_r;
    logic [N-1:0]  sum_r;

    assign fa_s = a_sh[0] ^ b_sh[0] ^ c;
    assign fa_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            s_sh     <= '0;
            c        <= 1'b0;
            c_msb_in <= 1'b0;
            cnt      <= '0;
            done_r   <= 1'b0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        c    <= cin;
                        cnt  <= '0;
                    end
                end
                ADD: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= {fa_s, s_sh[N-1:1]};
                    c    <= fa_c;
                    cnt  <= cnt + CW'(1);
                    // the carry leaving bit N-2 is the carry into the MSB
                    if (cnt == PENULT) c_msb_in <= fa_c;
                end
                DONE: begin
                    sum_r  <= s_sh;
                    cout_r <= c;
                    ovf_r  <= c_msb_in ^ c;
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = done_r;
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for the 4-bit serial adder: table of hand-computed results
// plus sequences for ignored start, abort by reset, reset/start collision and streaming.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst, start, cin;
    logic [3:0] a, b;
    logic       busy, done, cout, overflow;
    logic [3:0] sum;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.N(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one operation; watch cycles 0..8 after the accepting edge.
    task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                          input logic [3:0] es, input logic eco, input logic eov);
        int first_done, n_done, n_busy;
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(posedge clk);
        first_done = -1; n_done = 0; n_busy = 0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = 4'hx; b = 4'hx; cin = 1'bx;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
        end
        check("done_latency", first_done, 5);
        check("done_pulses", n_done, 1);
        check("busy_cycles", n_busy, 5);
        check("sum", sum, es);
        check("cout", cout, eco);
        check("overflow", overflow, eov);
        a = '0; b = '0; cin = 1'b0;
    endtask

    logic [3:0] sa[32], sb[32];
    logic       sc[32];
    logic [4:0] full;
    int         n_done, n_busy;

    initial begin
        vecs[0] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
        vecs[1] = '{4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b1};
        vecs[2] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[3] = '{4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0};
        vecs[4] = '{4'b1000, 4'b0111, 1'b1, 4'b0000, 1'b1, 1'b0};
        vecs[5] = '{4'b0100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[6] = '{4'b1001, 4'b1010, 1'b0, 4'b0011, 1'b1, 1'b1};
        vecs[7] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_ovf", overflow, 0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++)
            run_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].s, vecs[v].co, vecs[v].ov);

        // start pulsed during the 2nd ADD cycle must be ignored
        @(negedge clk);
        a = 4'b0001; b = 4'b0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        n_done = 0;
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin a = 4'b1111; b = 4'b1111; start = 1'b1; end
            else start = 1'b0;
            if (done) n_done++;
        end
        check("ign_done_pulses", n_done, 1);
        check("ign_sum", sum, 4'b0010);
        check("ign_cout", cout, 0);
        check("ign_busy_idle", busy, 0);

        // reset during the 3rd ADD cycle aborts the operation
        @(negedge clk);
        a = 4'b0111; b = 4'b0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        n_done = 0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (i == 2);
            if (done) n_done++;
        end
        check("abort_done_pulses", n_done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", overflow, 0);
        check("abort_busy", busy, 0);
        run_op(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);

        // rst and start on the same edge: start is dropped
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 4'b0011; b = 4'b0011;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_busy = 0; n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) n_done++;
        end
        check("collide_busy", n_busy, 0);
        check("collide_done", n_done, 0);
        check("collide_sum", sum, 0);

        // start held high with operands changing every cycle: accepts at edges 0,6,12,...
        @(negedge clk);
        sa[0] = 4'($urandom); sb[0] = 4'($urandom); sc[0] = 1'($urandom);
        a = sa[0]; b = sb[0]; cin = sc[0]; start = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("stream_done", done, (e % 6) == 5);
            if ((e % 6) == 5) begin
                full = {1'b0, sa[e-5]} + {1'b0, sb[e-5]} + {4'b0, sc[e-5]};
                check("stream_sum", sum, full[3:0]);
                check("stream_cout", cout, full[4]);
                check("stream_ovf", overflow,
                      (sa[e-5][3] == sb[e-5][3]) && (full[3] != sa[e-5][3]));
            end
            sa[e+1] = 4'($urandom); sb[e+1] = 4'($urandom); sc[e+1] = 1'($urandom);
            a = sa[e+1]; b = sb[e+1]; cin = sc[e+1];
            if (e == 29) start = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("stream_end_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
